router_1xn: RTL
===============

ROUTER_1XN -- requirements
Module: router_1xn

Interface
REQ-001 SHALL have parameter DW, 8, data/byte width in bits.
REQ-002 SHALL have parameter NCH, 3, number of output channels (2..8); ADDR_W = clog2(NCH).
REQ-003 SHALL have parameter DEPTH, 16, entries per channel FIFO (power of 2, >= 4).
REQ-004 SHALL have parameter TIMEOUT, 30, consecutive unread cycles before channel flush.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-007 SHALL have port packet_valid  input  1  high during header and payload bytes.
REQ-008 SHALL have port data_in  input  DW  header, payload or parity byte.
REQ-009 SHALL have port busy  output  1  source holds data_in and packet_valid while high.
REQ-010 SHALL have port read_enb  input  NCH  per-channel pop request.
REQ-011 SHALL have port vld_out  output  NCH  per-channel FIFO not empty.
REQ-012 SHALL have port data_out  output  NCH*DW  channel i on bits [i*DW +: DW].
REQ-013 SHALL have port err  output  3  one-cycle pulses {drop, length, parity}.
REQ-014 SHALL have port soft_reset  output  NCH  one-cycle pulse per channel timeout flush.

Function
REQ-015 Packet SHALL be: header (addr = data_in[ADDR_W-1:0], len = data_in[DW-1:ADDR_W]), len payload bytes with packet_valid=1, then parity byte (XOR of header and payloads) with packet_valid=0.
REQ-016 A byte SHALL be consumed on any rising edge where busy=0 in states DECODE (packet_valid=1), LOAD_DATA or DROP.
REQ-017 FSM states SHALL be DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK_PARITY, DROP; busy=1 in WAIT_EMPTY, LOAD_FIRST, CHECK_PARITY, and in LOAD_DATA while target FIFO full; busy=0 otherwise.
REQ-018 DECODE + packet_valid: latch header and addr; addr>=NCH -> DROP; target empty -> LOAD_FIRST; else -> WAIT_EMPTY.
REQ-019 WAIT_EMPTY SHALL go to LOAD_FIRST the cycle after target vld_out=0.
REQ-020 LOAD_FIRST SHALL write the header to the target FIFO with first-flag set, set parity accumulator = header, clear payload counter, -> LOAD_DATA.
REQ-021 LOAD_DATA, target not full: packet_valid=1 writes data_in, XORs accumulator, increments payload counter (saturating); packet_valid=0 writes data_in as parity, captures it, -> CHECK_PARITY; target full: no write, stay.
REQ-022 CHECK_PARITY SHALL pulse err[0] if captured parity != accumulator and err[1] if payload count != len, then -> DECODE.
REQ-023 DROP SHALL consume bytes without FIFO writes until the packet_valid=0 byte, pulse err[2] on that edge, -> DECODE.
REQ-024 FIFO write and read in the same cycle SHALL both occur, occupancy unchanged; write when full and read when empty SHALL be ignored.
REQ-025 read_enb[i] with vld_out[i]=1 SHALL register head entry onto data_out channel i one cycle later; data_out SHALL otherwise hold.
REQ-026 vld_out[i] SHALL be combinational from occupancy != 0.
REQ-027 Per-channel timeout counter SHALL increment while vld_out[i]=1 and read_enb[i]=0, clear otherwise; on reaching TIMEOUT the next edge SHALL clear FIFO i and data_out channel i and pulse soft_reset[i].
REQ-028 Flush of the current target in WAIT_EMPTY, LOAD_FIRST or LOAD_DATA SHALL send the FSM to DROP (err[2] pulses at packet end).
REQ-029 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be clog2(DEPTH)+1 bits.

Reset
REQ-030 resetn=0 at an edge SHALL: state DECODE, all FIFOs empty, counters 0, data_out 0, err 0, soft_reset 0; hence busy=0, vld_out 0; mid-packet reset abandons the packet.

Verification (NCH=3, DW=8, DEPTH=16, TIMEOUT=30)
REQ-031 Header 8'h0D, payload 11,22,33, parity 8'h0D -> channel 1 holds 5 entries, vld_out=3'b010 two cycles after header, err never pulses.
REQ-032 Same packet with parity 8'hFF -> err=3'b001 for exactly one cycle after CHECK_PARITY.
REQ-033 Header 8'h03 (addr 3) + 2 payload + parity -> no FIFO writes, err=3'b100 pulse, busy stays 0.
REQ-034 Header len 20 to channel 0, no reads -> busy=1 after 16 entries; single read_enb[0] -> exactly one more byte accepted.
REQ-035 Channel 2 loaded, read_enb[2]=0 for 30 cycles -> soft_reset[2] pulse next edge, vld_out[2]=0 same cycle, data_out[23:16]=0.
REQ-036 resetn=0 one cycle mid LOAD_DATA -> all vld_out 0, busy 0, next header routes normally.

Source files
------------

// File: rtl/router_1xn.sv
// 1-to-N packet router: header/payload/parity byte stream steered into per-channel FIFOs,
// with parity/length checking, drop of bad addresses and per-channel unread-timeout flush.
module router_1xn #(
    parameter int unsigned DW      = 8,
    parameter int unsigned NCH     = 3,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [DW-1:0]     data_in,
    output logic              busy,
    input  logic [NCH-1:0]    read_enb,
    output logic [NCH-1:0]    vld_out,
    output logic [NCH*DW-1:0] data_out,
    output logic [2:0]        err,
    output logic [NCH-1:0]    soft_reset
);

    localparam int unsigned ADDR_W = $clog2(NCH);
    localparam int unsigned LEN_W  = DW - ADDR_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] DECODE       = 3'd0;
    localparam logic [2:0] WAIT_EMPTY   = 3'd1;
    localparam logic [2:0] LOAD_FIRST   = 3'd2;
    localparam logic [2:0] LOAD_DATA    = 3'd3;
    localparam logic [2:0] CHECK_PARITY = 3'd4;
    localparam logic [2:0] DROP         = 3'd5;

    logic [2:0]        state, next_state;
    logic [DW-1:0]     hdr_q, hdr_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     cap_q, cap_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        err_d;
    logic [NCH-1:0]    wr_en_c;
    logic [DW:0]       wr_data_c;
    logic [NCH-1:0]    full_v, flush_v;
    logic [ADDR_W-1:0] addr_c;
    logic [LEN_W-1:0]  len_c;
    logic              tgt_full_c, tgt_flush_c;

    assign addr_c      = hdr_q[ADDR_W-1:0];
    assign len_c       = hdr_q[DW-1:ADDR_W];
    assign tgt_full_c  = full_v[addr_c];
    assign tgt_flush_c = flush_v[addr_c];

    // Source must hold its byte whenever the FSM cannot take it this edge
    assign busy = (state == WAIT_EMPTY) || (state == LOAD_FIRST) || (state == CHECK_PARITY) ||
                  ((state == LOAD_DATA) && tgt_full_c);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= DECODE;
            hdr_q <= '0;
            acc_q <= '0;
            cap_q <= '0;
            cnt_q <= '0;
            err   <= '0;
        end else begin
            state <= next_state;
            hdr_q <= hdr_d;
            acc_q <= acc_d;
            cap_q <= cap_d;
            cnt_q <= cnt_d;
            err   <= err_d;
        end
    end

    always_comb begin
        next_state = state;
        hdr_d      = hdr_q;
        acc_d      = acc_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        err_d      = '0;
        wr_en_c    = '0;
        wr_data_c  = '0;
        unique case (state)
            DECODE: begin
                if (packet_valid) begin
                    hdr_d = data_in;
                    if (32'(data_in[ADDR_W-1:0]) >= NCH) begin
                        next_state = DROP;
                    end else if (!vld_out[data_in[ADDR_W-1:0]]) begin
                        next_state = LOAD_FIRST;
                    end else begin
                        next_state = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                if (tgt_flush_c) begin
                    next_state = DROP;
                end else if (!vld_out[addr_c]) begin
                    next_state = LOAD_FIRST;
                end
            end
            LOAD_FIRST: begin
                if (tgt_flush_c) begin
                    next_state = DROP;
                end else begin
                    wr_en_c[addr_c] = 1'b1;
                    wr_data_c       = {1'b1, hdr_q};
                    acc_d           = hdr_q;
                    cnt_d           = '0;
                    next_state      = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                // A flush mid-packet still consumes the byte on offer; if that was the
                // parity byte the packet has already ended, so report the drop now.
                if (tgt_flush_c) begin
                    if (!tgt_full_c && !packet_valid) begin
                        err_d[2]   = 1'b1;
                        next_state = DECODE;
                    end else begin
                        next_state = DROP;
                    end
                end else if (!tgt_full_c) begin
                    wr_en_c[addr_c] = 1'b1;
                    wr_data_c       = {1'b0, data_in};
                    if (packet_valid) begin
                        acc_d = acc_q ^ data_in;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + LEN_W'(1);
                        end
                    end else begin
                        cap_d      = data_in;
                        next_state = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                err_d[0]   = (cap_q != acc_q);
                err_d[1]   = (cnt_q != len_c);
                next_state = DECODE;
            end
            DROP: begin
                if (!packet_valid) begin
                    err_d[2]   = 1'b1;
                    next_state = DECODE;
                end
            end
            default: next_state = DECODE;
        endcase
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW:0]      mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr, rd_ptr;
        logic [OCC_W-1:0] occ;
        logic [TMR_W-1:0] tmr;
        logic [DW-1:0]    dout_q;
        logic             sr_q;
        logic             do_wr, do_rd;
        logic [DW:0]      head;
        // First-of-packet flag travels with each entry; no port on this block consumes it
        logic             unused_head_first;

        assign vld_out[i]             = (occ != '0);
        assign full_v[i]              = (occ == OCC_W'(DEPTH));
        assign flush_v[i]             = (tmr == TMR_W'(TIMEOUT));
        assign do_wr                  = wr_en_c[i] && !full_v[i] && !flush_v[i];
        assign do_rd                  = read_enb[i] && vld_out[i];
        assign head                   = mem[rd_ptr];
        assign unused_head_first      = head[DW];
        assign data_out[i*DW +: DW]   = dout_q;
        assign soft_reset[i]          = sr_q;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                tmr    <= '0;
                dout_q <= '0;
                sr_q   <= 1'b0;
            end else if (flush_v[i]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                tmr    <= '0;
                dout_q <= '0;
                sr_q   <= 1'b1;
            end else begin
                sr_q <= 1'b0;
                if (do_wr) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_rd) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    dout_q <= head[DW-1:0];
                end
                occ <= occ + OCC_W'(do_wr) - OCC_W'(do_rd);
                tmr <= (vld_out[i] && !read_enb[i]) ? tmr + TMR_W'(1) : '0;
            end
        end

        always_ff @(posedge clk) begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data_c;
            end
        end
    end

endmodule
